// File: rtl/axi4_lite_pkg.sv
// Shared definitions for the AXI4-Lite slave-to-memory bridge.
// Holds the AXI response codes, the bridge FSM state encoding, the
// last-grant encoding for round-robin arbitration, and the address helpers
// used to turn a granted AXI byte address into a window offset and a
// response code.
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WR_ACC = 2'd1,
        ST_RD_ACC = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_READ  = 1'b0,
        GRANT_WRITE = 1'b1
    } grant_t;

    // Byte offset of an address inside the decoded window.
    function automatic logic [63:0] addr_offset(input logic [63:0] addr,
                                                input logic [63:0] base);
        return addr - base;
    endfunction

    // Response code for an access. Decode failure outranks misalignment,
    // which outranks the protection check. The window test relies on the
    // base being aligned to the (power-of-two) span.
    function automatic logic [1:0] addr_check(input logic [63:0]   addr,
                                              input logic [63:0]   base,
                                              input logic [63:0]   span,
                                              input int unsigned   bus_bytes,
                                              input logic [2:0]    prot,
                                              input logic          secure_only);
        logic [63:0] align_mask;
        logic [1:0]  code;
        align_mask = 64'(bus_bytes) - 64'd1;
        if ((addr & ~(span - 64'd1)) != base) begin
            code = RESP_DECERR;
        end else if ((addr & align_mask) != 64'd0) begin
            code = RESP_SLVERR;
        end else if (secure_only && prot[1]) begin
            code = RESP_SLVERR;
        end else begin
            code = RESP_OKAY;
        end
        return code;
    endfunction

endpackage

// File: rtl/axi4_lite_hold_reg.sv
// Single-entry valid/ready holding register.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   valid, ready    upstream handshake; ready is simply "not full"
//   data_in         payload captured on the valid && ready edge
//   clear           empties the entry (the consumer is done with it)
//   full, data_out  entry state and stored payload
module axi4_lite_hold_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    output logic             ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic             clear,
    output logic             full,
    output logic [WIDTH-1:0] data_out
);

    assign ready = !full;

    // Capture and clear never coincide: capture needs the entry empty,
    // clear is only issued while it is full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full     <= 1'b0;
            data_out <= '0;
        end else if (valid && ready) begin
            full     <= 1'b1;
            data_out <= data_in;
        end else if (clear) begin
            full     <= 1'b0;
        end
    end

endmodule

// File: rtl/axi4_lite_slave_bridge.sv
// AXI4-Lite slave to single-port memory bridge.
// AW, W and AR are each buffered in a one-entry holding register, so AW and
// W can arrive in any order. One write and one read may be outstanding;
// the FSM arbitrates between them, checks the granted address and either
// runs a memory access (req held until mem_ready) or answers an error
// directly.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   aw*/w*/b*, ar*/r*                AXI4-Lite slave channels
//   mem_req/mem_we/mem_addr          memory request, direction, byte offset
//   mem_wdata/mem_wstrb              write payload (strobes zero on reads)
//   mem_rdata/mem_ready              read data and completion from memory
module axi4_lite_slave_bridge
    import axi4_lite_pkg::*;
#(
    parameter int              ADDR_WIDTH  = 32,
    parameter int              DATA_WIDTH  = 32,
    parameter longint unsigned BASE_ADDR   = 0,
    parameter longint unsigned ADDR_SPAN   = 4096,
    parameter int              ARB_MODE    = 0,
    parameter int              SECURE_ONLY = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [2:0]              awprot,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [2:0]              arprot,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rvalid,
    input  logic                    rready,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_ready
);

    localparam int STRB_W = DATA_WIDTH / 8;

    state_t state, state_next;
    grant_t last_grant;

    logic                    aw_full, w_full, ar_full;
    logic [ADDR_WIDTH+2:0]   aw_q, ar_q;
    logic [DATA_WIDTH+STRB_W-1:0] w_q;
    logic [ADDR_WIDTH-1:0]   aw_addr, ar_addr;
    logic [2:0]              aw_prot, ar_prot;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [STRB_W-1:0]       w_strb;

    logic       wr_elig, rd_elig, grant_wr, grant_rd;
    logic [1:0] wr_code, rd_code;
    logic       wr_done, rd_done, rd_from_mem;
    logic [1:0] wr_resp, rd_resp;

    axi4_lite_hold_reg #(.WIDTH(ADDR_WIDTH + 3)) u_aw_hold (
        .clk(clk), .rst_n(rst_n), .valid(awvalid), .ready(awready),
        .data_in({awaddr, awprot}), .clear(wr_done), .full(aw_full), .data_out(aw_q)
    );

    axi4_lite_hold_reg #(.WIDTH(DATA_WIDTH + STRB_W)) u_w_hold (
        .clk(clk), .rst_n(rst_n), .valid(wvalid), .ready(wready),
        .data_in({wdata, wstrb}), .clear(wr_done), .full(w_full), .data_out(w_q)
    );

    axi4_lite_hold_reg #(.WIDTH(ADDR_WIDTH + 3)) u_ar_hold (
        .clk(clk), .rst_n(rst_n), .valid(arvalid), .ready(arready),
        .data_in({araddr, arprot}), .clear(rd_done), .full(ar_full), .data_out(ar_q)
    );

    assign aw_addr = aw_q[ADDR_WIDTH+2:3];
    assign aw_prot = aw_q[2:0];
    assign ar_addr = ar_q[ADDR_WIDTH+2:3];
    assign ar_prot = ar_q[2:0];
    assign w_data  = w_q[DATA_WIDTH+STRB_W-1:STRB_W];
    assign w_strb  = w_q[STRB_W-1:0];

    // A direction is only eligible once its previous response has been
    // consumed, which keeps one transaction per direction in flight.
    assign wr_elig = aw_full && w_full && !bvalid;
    assign rd_elig = ar_full && !rvalid;

    assign wr_code = addr_check(64'(aw_addr), BASE_ADDR, ADDR_SPAN, STRB_W,
                                aw_prot, SECURE_ONLY != 0);
    assign rd_code = addr_check(64'(ar_addr), BASE_ADDR, ADDR_SPAN, STRB_W,
                                ar_prot, SECURE_ONLY != 0);

    // Arbitration only matters when both directions are eligible; in
    // round-robin mode the direction not granted last time wins.
    always_comb begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (state == ST_IDLE) begin
            if (wr_elig && rd_elig) begin
                if (ARB_MODE == 0 || last_grant == GRANT_READ) begin
                    grant_wr = 1'b1;
                end else begin
                    grant_rd = 1'b1;
                end
            end else begin
                grant_wr = wr_elig;
                grant_rd = rd_elig;
            end
        end
    end

    // Error grants complete on the grant edge without touching memory;
    // OKAY grants move to the access state and complete on mem_ready.
    always_comb begin
        state_next  = state;
        wr_done     = 1'b0;
        rd_done     = 1'b0;
        rd_from_mem = 1'b0;
        wr_resp     = RESP_OKAY;
        rd_resp     = RESP_OKAY;
        case (state)
            ST_IDLE: begin
                if (grant_wr) begin
                    if (wr_code == RESP_OKAY) begin
                        state_next = ST_WR_ACC;
                    end else begin
                        wr_done = 1'b1;
                        wr_resp = wr_code;
                    end
                end else if (grant_rd) begin
                    if (rd_code == RESP_OKAY) begin
                        state_next = ST_RD_ACC;
                    end else begin
                        rd_done = 1'b1;
                        rd_resp = rd_code;
                    end
                end
            end
            ST_WR_ACC: begin
                if (mem_ready) begin
                    state_next = ST_IDLE;
                    wr_done    = 1'b1;
                end
            end
            ST_RD_ACC: begin
                if (mem_ready) begin
                    state_next  = ST_IDLE;
                    rd_done     = 1'b1;
                    rd_from_mem = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State, arbitration history and the registered response channels.
    // Responses hold until their handshake; a new completion cannot collide
    // with a pending response because eligibility excludes that case.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            last_grant <= GRANT_READ;
            bvalid     <= 1'b0;
            bresp      <= RESP_OKAY;
            rvalid     <= 1'b0;
            rresp      <= RESP_OKAY;
            rdata      <= '0;
        end else begin
            state <= state_next;
            if (grant_wr) begin
                last_grant <= GRANT_WRITE;
            end else if (grant_rd) begin
                last_grant <= GRANT_READ;
            end
            if (wr_done) begin
                bvalid <= 1'b1;
                bresp  <= wr_resp;
            end else if (bready) begin
                bvalid <= 1'b0;
            end
            if (rd_done) begin
                rvalid <= 1'b1;
                rresp  <= rd_resp;
                rdata  <= rd_from_mem ? mem_rdata : '0;
            end else if (rready) begin
                rvalid <= 1'b0;
            end
        end
    end

    // The holding registers cannot change while their entry is in use, so
    // driving the memory side straight from them keeps it stable under req.
    assign mem_req   = (state != ST_IDLE);
    assign mem_we    = (state == ST_WR_ACC);
    assign mem_addr  = ADDR_WIDTH'(addr_offset(64'((state == ST_RD_ACC) ? ar_addr : aw_addr),
                                               BASE_ADDR));
    assign mem_wdata = w_data;
    assign mem_wstrb = mem_we ? w_strb : '0;

endmodule

// File: tb/tb_axi4_lite_slave_bridge.sv
// Self-checking bench for axi4_lite_slave_bridge.
// dut_a (round-robin, secure-only) is fully scoreboarded: expected memory
// accesses, B and R responses are queued by the stimulus and popped by a
// monitor. dut_b (fixed write priority) shares the AXI inputs and is only
// watched for its memory access order during the arbitration scenario.
module tb_axi4_lite_slave_bridge;

    import axi4_lite_pkg::*;

    logic        clk, rst_n;
    logic [31:0] awaddr, araddr, wdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, arvalid, bready, rready, rready_b;

    logic        awready, wready, arready, bvalid, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    logic        awready_b, wready_b, arready_b, bvalid_b, rvalid_b;
    logic [1:0]  bresp_b, rresp_b;
    logic [31:0] rdata_b;
    logic        mem_req_b, mem_we_b, mem_ready_b;
    logic [31:0] mem_addr_b, mem_wdata_b, mem_rdata_b;
    logic [3:0]  mem_wstrb_b;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
        int          due;
    } resp_exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          due;
        int          len;
    } mem_exp_t;

    resp_exp_t exp_b[$];
    resp_exp_t exp_r[$];
    mem_exp_t  exp_m[$];
    logic      exp_order[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ready_delay = 0;
    int r_hold = 0;
    logic order_en = 1'b0;
    logic [31:0] mem_model [0:63];

    axi4_lite_slave_bridge #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(0), .ADDR_SPAN(4096),
        .ARB_MODE(1), .SECURE_ONLY(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    axi4_lite_slave_bridge #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(0), .ADDR_SPAN(4096),
        .ARB_MODE(0), .SECURE_ONLY(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready_b),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready_b),
        .bresp(bresp_b), .bvalid(bvalid_b), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready_b),
        .rdata(rdata_b), .rresp(rresp_b), .rvalid(rvalid_b), .rready(rready_b),
        .mem_req(mem_req_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_wstrb(mem_wstrb_b),
        .mem_rdata(mem_rdata_b), .mem_ready(mem_ready_b)
    );

    assign mem_ready_b = 1'b1;
    assign mem_rdata_b = 32'h0;
    assign rready_b    = 1'b1;
    assign mem_rdata   = mem_model[mem_addr[7:2]];

    // Free-running clock and a cycle counter equal to the number of rising
    // edges seen so far.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model for dut_a: byte-strobed writes on the completion edge.
    always @(posedge clk) begin
        if (mem_req && mem_ready && mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wstrb[b]) mem_model[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    // mem_ready rises in the (ready_delay+1)-th cycle of a request.
    initial begin
        int req_cnt;
        req_cnt = 0;
        mem_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req && rst_n) begin
                mem_ready = (req_cnt == ready_delay);
                req_cnt++;
            end else begin
                mem_ready = 1'b0;
                req_cnt = 0;
            end
        end
    end

    // rready is withheld for r_hold cycles after rvalid appears.
    initial begin
        int r_wait;
        r_wait = 0;
        rready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rvalid) begin
                r_wait = 0;
                rready = 1'b0;
            end else begin
                rready = (r_wait >= r_hold);
                r_wait++;
            end
        end
    end

    // Common comparison: counts every check and reports a FAIL line.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic expectB(input logic [1:0] resp, input int due);
        resp_exp_t e;
        e.resp = resp; e.data = 32'h0; e.due = due;
        exp_b.push_back(e);
    endtask

    task automatic expectR(input logic [1:0] resp, input logic [31:0] data, input int due);
        resp_exp_t e;
        e.resp = resp; e.data = data; e.due = due;
        exp_r.push_back(e);
    endtask

    task automatic expectM(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] ws, input int due, input int len);
        mem_exp_t e;
        e.we = we; e.addr = addr; e.wdata = wd; e.wstrb = ws; e.due = due; e.len = len;
        exp_m.push_back(e);
    endtask

    // Monitor: samples on the falling edge, pops expectations whenever the
    // DUT completes a memory access or a response handshake.
    initial begin
        logic b_prev, r_prev, m_prev;
        int b_rise, r_rise, m_rise, m_len;
        resp_exp_t e;
        mem_exp_t me;
        logic ord;
        b_prev = 1'b0; r_prev = 1'b0; m_prev = 1'b0;
        b_rise = 0; r_rise = 0; m_rise = 0; m_len = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                b_prev = 1'b0; r_prev = 1'b0; m_prev = 1'b0;
            end else begin
                if (mem_req && !m_prev) begin
                    m_rise = cyc;
                    m_len = 0;
                end
                if (mem_req) m_len++;
                m_prev = mem_req;
                if (mem_req && mem_ready) begin
                    if (exp_m.size() == 0) begin
                        checkOutput("mem_unexpected", 64'(mem_addr), 64'hFFFF_FFFF);
                    end else begin
                        me = exp_m.pop_front();
                        checkOutput("mem_we", 64'(mem_we), 64'(me.we));
                        checkOutput("mem_addr", 64'(mem_addr), 64'(me.addr));
                        checkOutput("mem_wstrb", 64'(mem_wstrb), 64'(me.wstrb));
                        if (me.we) checkOutput("mem_wdata", 64'(mem_wdata), 64'(me.wdata));
                        checkOutput("mem_req_start", 64'(m_rise), 64'(me.due));
                        checkOutput("mem_req_len", 64'(m_len), 64'(me.len));
                    end
                end

                if (bvalid && !b_prev) b_rise = cyc;
                b_prev = bvalid;
                if (bvalid && bready) begin
                    if (exp_b.size() == 0) begin
                        checkOutput("b_unexpected", 64'(bresp), 64'hF);
                    end else begin
                        e = exp_b.pop_front();
                        checkOutput("bresp", 64'(bresp), 64'(e.resp));
                        checkOutput("b_latency", 64'(b_rise), 64'(e.due));
                    end
                end

                if (rvalid && !r_prev) r_rise = cyc;
                r_prev = rvalid;
                if (rvalid && rready) begin
                    if (exp_r.size() == 0) begin
                        checkOutput("r_unexpected", 64'(rresp), 64'hF);
                    end else begin
                        e = exp_r.pop_front();
                        checkOutput("rresp", 64'(rresp), 64'(e.resp));
                        checkOutput("rdata", 64'(rdata), 64'(e.data));
                        checkOutput("r_latency", 64'(r_rise), 64'(e.due));
                    end
                end else if (rvalid && exp_r.size() > 0) begin
                    checkOutput("rdata_held", 64'(rdata), 64'(exp_r[0].data));
                    checkOutput("rresp_held", 64'(rresp), 64'(exp_r[0].resp));
                end

                if (order_en && mem_req_b && mem_ready_b) begin
                    if (exp_order.size() == 0) begin
                        checkOutput("order_b_unexpected", 64'(mem_we_b), 64'h2);
                    end else begin
                        ord = exp_order.pop_front();
                        checkOutput("order_b_we", 64'(mem_we_b), 64'(ord));
                    end
                end
            end
        end
    end

    // Drives the requested AXI channels together, drops each valid after its
    // handshake and returns the edge number of the last handshake.
    task automatic applyStimulus(input logic do_aw, input logic do_w, input logic do_ar,
                                 input logic [31:0] aw_a, input logic [2:0] aw_p,
                                 input logic [31:0] wd, input logic [3:0] ws,
                                 input logic [31:0] ar_a, input logic [2:0] ar_p,
                                 output int hs);
        int guard;
        logic acc_aw, acc_w, acc_ar;
        guard = 0;
        hs = cyc;
        awaddr = aw_a; awprot = aw_p; wdata = wd; wstrb = ws; araddr = ar_a; arprot = ar_p;
        awvalid = do_aw; wvalid = do_w; arvalid = do_ar;
        while ((awvalid || wvalid || arvalid) && guard < 40) begin
            acc_aw = awvalid && awready;
            acc_w  = wvalid && wready;
            acc_ar = arvalid && arready;
            @(posedge clk);
            #1;
            if (acc_aw) awvalid = 1'b0;
            if (acc_w)  wvalid  = 1'b0;
            if (acc_ar) arvalid = 1'b0;
            if (acc_aw || acc_w || acc_ar) hs = cyc;
            guard++;
        end
        if (awvalid || wvalid || arvalid) begin
            checkOutput("handshake_timeout", 64'(guard), 64'd0);
            awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        end
    endtask

    // Waits, with a cycle budget, until every expectation has been consumed.
    task automatic waitIdle();
        int guard;
        guard = 0;
        while ((exp_b.size() != 0 || exp_r.size() != 0 || exp_m.size() != 0 ||
                mem_req || bvalid || rvalid) && guard < 60) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 60) begin
            checkOutput("idle_timeout", 64'(exp_b.size() + exp_r.size() + exp_m.size()), 64'd0);
            exp_b.delete(); exp_r.delete(); exp_m.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Directed scenario sequence.
    initial begin
        int hs;
        rst_n = 1'b0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b1;
        awaddr = 32'h0; awprot = 3'b000; wdata = 32'h0; wstrb = 4'h0;
        araddr = 32'h0; arprot = 3'b000;
        repeat (2) begin @(posedge clk); #1; end

        $display("[TB] reset state");
        checkOutput("rst_awready", 64'(awready), 64'd1);
        checkOutput("rst_wready", 64'(wready), 64'd1);
        checkOutput("rst_arready", 64'(arready), 64'd1);
        checkOutput("rst_mem_req", 64'(mem_req), 64'd0);
        checkOutput("rst_bvalid", 64'(bvalid), 64'd0);
        checkOutput("rst_rvalid", 64'(rvalid), 64'd0);
        checkOutput("rst_bresp", 64'(bresp), 64'd0);
        checkOutput("rst_rdata", 64'(rdata), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] W before AW, write 0x10");
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 3'b000, 32'hDEADBEEF, 4'hF, 32'h0, 3'b000, hs);
        repeat (2) begin @(posedge clk); #1; end
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h10, 3'b000, 32'hDEADBEEF, 4'hF, 32'h0, 3'b000, hs);
        expectM(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, hs + 1, 1);
        expectB(RESP_OKAY, hs + 2);
        waitIdle();

        $display("[TB] slow memory read with rready back-pressure");
        ready_delay = 3;
        r_hold = 2;
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 3'b000, 32'h0, 4'h0, 32'h10, 3'b000, hs);
        expectM(1'b0, 32'h10, 32'h0, 4'h0, hs + 1, 4);
        expectR(RESP_OKAY, 32'hDEADBEEF, hs + 5);
        waitIdle();
        ready_delay = 0;
        r_hold = 0;

        $display("[TB] decode and alignment errors");
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 3'b000, 32'h0, 4'h0, 32'h1000, 3'b000, hs);
        expectR(RESP_DECERR, 32'h0, hs + 1);
        waitIdle();
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 3'b000, 32'h0, 4'h0, 32'h2, 3'b000, hs);
        expectR(RESP_SLVERR, 32'h0, hs + 1);
        waitIdle();

        $display("[TB] protection check");
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h40, 3'b010, 32'h11111111, 4'hF, 32'h0, 3'b000, hs);
        expectB(RESP_SLVERR, hs + 1);
        waitIdle();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h40, 3'b000, 32'h0BADC0DE, 4'hF, 32'h0, 3'b000, hs);
        expectM(1'b1, 32'h40, 32'h0BADC0DE, 4'hF, hs + 1, 1);
        expectB(RESP_OKAY, hs + 2);
        waitIdle();

        // Last grant was a write, so round-robin serves the read first and
        // the read must still see the old word; fixed priority does the
        // write first.
        $display("[TB] simultaneous AW, W and AR");
        exp_order.push_back(1'b1);
        exp_order.push_back(1'b0);
        order_en = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h10, 3'b000, 32'hCAFEF00D, 4'b0101, 32'h10, 3'b000, hs);
        expectM(1'b0, 32'h10, 32'h0, 4'h0, hs + 1, 1);
        expectR(RESP_OKAY, 32'hDEADBEEF, hs + 2);
        expectM(1'b1, 32'h10, 32'hCAFEF00D, 4'b0101, hs + 3, 1);
        expectB(RESP_OKAY, hs + 4);
        waitIdle();
        checkOutput("order_b_left", 64'(exp_order.size()), 64'd0);
        order_en = 1'b0;

        $display("[TB] read back merged and full words");
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 3'b000, 32'h0, 4'h0, 32'h10, 3'b000, hs);
        expectM(1'b0, 32'h10, 32'h0, 4'h0, hs + 1, 1);
        expectR(RESP_OKAY, 32'hDEFEBE0D, hs + 2);
        waitIdle();
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 3'b000, 32'h0, 4'h0, 32'h40, 3'b000, hs);
        expectM(1'b0, 32'h40, 32'h0, 4'h0, hs + 1, 1);
        expectR(RESP_OKAY, 32'h0BADC0DE, hs + 2);
        waitIdle();

        $display("[TB] reset during a write access");
        ready_delay = 1000;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h30, 3'b000, 32'h55AA55AA, 4'hF, 32'h0, 3'b000, hs);
        @(posedge clk); #1;
        checkOutput("abort_mem_req_before", 64'(mem_req), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_mem_req", 64'(mem_req), 64'd0);
        checkOutput("abort_bvalid", 64'(bvalid), 64'd0);
        checkOutput("abort_awready", 64'(awready), 64'd1);
        checkOutput("abort_wready", 64'(wready), 64'd1);
        repeat (2) begin @(posedge clk); #1; end
        ready_delay = 0;
        rst_n = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        checkOutput("post_rst_awready", 64'(awready), 64'd1);
        checkOutput("post_rst_wready", 64'(wready), 64'd1);
        checkOutput("post_rst_arready", 64'(arready), 64'd1);
        checkOutput("post_rst_bvalid", 64'(bvalid), 64'd0);
        checkOutput("post_rst_rvalid", 64'(rvalid), 64'd0);
        checkOutput("post_rst_mem_req", 64'(mem_req), 64'd0);
        checkOutput("left_expectations", 64'(exp_b.size() + exp_r.size() + exp_m.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case the sequence itself stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
